// File: rtl/blaze_frame_transmitter.sv
// -----------------------------------------------------------------------------
// blaze_frame_transmitter
//
// Host-side command framer for microblaze_mips_interface. Each accepted command
// is packed into one 32-bit control frame:
//
//   {code[31:26], valid[25], sel[24:16], addr[15:0]}
//
// The receiver reacts to a 0->1 edge on the valid bit. Every command therefore
// gets a valid=1 hold window followed by a valid=0 gap. Between two commands
// the block spends at least one cycle in IDLE with valid=0, so repeated
// identical commands still give the receiver a fresh edge. A REQ_DATA command
// also waits a fixed time after the gap and then captures the reply frame.
//
// Sequence per command (cycle 0 = accept cycle):
//   cycle 1 .. HOLD                 : frame = {code, 1, sel, addr}
//   next GAP_CYCLES cycles          : frame = {code, 0, sel, addr}
//   REQ_DATA only, RSP_WAIT cycles  : frame unchanged, reply sampled on the last
//   afterwards                      : IDLE, ready = 1 (o_rsp_valid pulses in the
//                                     same cycle for REQ_DATA)
//
// Ports
//   i_clock            in   1   clock, every flop uses its rising edge
//   i_reset            in   1   synchronous, active-high reset
//   i_cmd_valid        in   1   command request
//   o_cmd_ready        out  1   high only in IDLE; accept = valid & ready
//   i_cmd_code         in   6   command code
//   i_cmd_sel          in   9   register/memory select field
//   i_cmd_addr         in   16  address field
//   o_frame_to_mips    out  32  registered frame driven to the interface
//   i_frame_from_mips  in   32  reply frame from the interface
//   o_rsp_valid        out  1   one-cycle pulse when a reply has been captured
//   o_rsp_data         out  32  last captured reply, held until the next capture
//   o_cmd_count        out  16  accepted-command count (only with the macro)
//   o_busy             out  1   inverse of o_cmd_ready
//
// Build option
//   BLAZE_TX_CMD_COUNT_EN : when defined, adds o_cmd_count. It counts accepted
//                           commands, wraps from 16'hFFFF to 0, and clears on
//                           reset. When undefined, the port and its counter are
//                           absent and nothing else changes.
// -----------------------------------------------------------------------------
module blaze_frame_transmitter #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_ADDR_DATA     = 16,
  parameter int NB_CODE          = 6,
  parameter int NB_SEL           = 9,
  parameter int HOLD_CYCLES      = 2,
  parameter int GAP_CYCLES       = 2,
  parameter int RSP_WAIT         = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [NB_CODE-1:0]          i_cmd_code,
  input  logic [NB_SEL-1:0]           i_cmd_sel,
  input  logic [NB_ADDR_DATA-1:0]     i_cmd_addr,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_mips,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_mips,
  output logic                        o_rsp_valid,
  output logic [NB_CONTROL_FRAME-1:0] o_rsp_data,
`ifdef BLAZE_TX_CMD_COUNT_EN
  output logic [15:0]                 o_cmd_count,
`endif
  output logic                        o_busy
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  // The valid bit sits directly above the sel and addr fields.
  localparam int VALID_BIT = NB_ADDR_DATA + NB_SEL;

  // One shared phase counter serves HOLD, GAP and WAIT. It is cleared on every
  // state change and never counts past the longest phase, so it cannot wrap.
  localparam int MAX_HG     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES = (MAX_HG > RSP_WAIT) ? MAX_HG : RSP_WAIT;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RSP_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // REQ_DATA is the only code with reply handling. START (000001),
  // RESET (000010), SET_MODE (001010), STEP (100000) and any other code are
  // framed identically and return to IDLE after the gap.
  localparam logic [NB_CODE-1:0] CODE_REQ_DATA = NB_CODE'(3);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                        state_q,     state_d;
  logic [CNT_W-1:0]              cnt_q,       cnt_d;
  logic [NB_CONTROL_FRAME-1:0]   frame_q,     frame_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [NB_CONTROL_FRAME-1:0]   rsp_data_q,  rsp_data_d;

  logic                          cmd_accept;
  logic                          is_req_data;

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = ~o_cmd_ready;
  assign cmd_accept  = i_cmd_valid & o_cmd_ready;

  // The frame register holds the command fields for the whole command, so the
  // code decides whether a reply phase follows the gap.
  assign is_req_data = (frame_q[NB_CONTROL_FRAME-1 -: NB_CODE] == CODE_REQ_DATA);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default before the case statement. A branch
  // that leaves a signal unassigned then means "hold" or "idle", and no latch
  // is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          frame_d = {i_cmd_code, 1'b1, i_cmd_sel, i_cmd_addr};
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          // Clear only the valid bit. The receiver may still be decoding the
          // other fields.
          frame_d[VALID_BIT] = 1'b0;
          cnt_d              = '0;
          state_d            = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = is_req_data ? ST_WAIT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          rsp_data_d  = i_frame_from_mips;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every flop then
  // samples the pre-edge values, whatever order the statements are in.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // Reset wins over a same-cycle accept, so that command is dropped.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_frame_to_mips = frame_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_data      = rsp_data_q;

`ifdef BLAZE_TX_CMD_COUNT_EN
  // ---------------------------------------------------------------------------
  // Accepted-command counter. It wraps naturally at 16 bits.
  // ---------------------------------------------------------------------------
  logic [15:0] cmd_count_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cmd_count_q <= '0;
    end else if (cmd_accept) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign o_cmd_count = cmd_count_q;
`endif

endmodule

// File: tb/tb_blaze_frame_transmitter.sv
// -----------------------------------------------------------------------------
// tb_blaze_frame_transmitter
//
// Self-checking bench for blaze_frame_transmitter.
//   - Table of directed vectors: reset, RESET command, back-to-back SET_MODE
//     and START with valid held high, and commands ignored while busy.
//   - Hand-written sequences: REQ_DATA reply latency and hold, reset in the
//     middle of a command, and a reset in the same cycle as a request.
//   - Randomized traffic checked against a transaction-level model. The model
//     tracks only the accept time and the command fields, and derives each
//     expected output from the elapsed time since the accept.
// -----------------------------------------------------------------------------
module tb_blaze_frame_transmitter;

  localparam int H = 2;  // HOLD_CYCLES
  localparam int G = 2;  // GAP_CYCLES
  localparam int W = 4;  // RSP_WAIT

  localparam logic [5:0] C_START    = 6'b000001;
  localparam logic [5:0] C_RESET    = 6'b000010;
  localparam logic [5:0] C_REQ_DATA = 6'b000011;
  localparam logic [5:0] C_SET_MODE = 6'b001010;
  localparam logic [5:0] C_STEP     = 6'b100000;

  // ---------------------------------------------------------------------------
  // DUT connections
  // ---------------------------------------------------------------------------
  logic        tb_clock_i = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [5:0]  i_cmd_code;
  logic [8:0]  i_cmd_sel;
  logic [15:0] i_cmd_addr;
  logic [31:0] o_frame_to_mips;
  logic [31:0] i_frame_from_mips;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_busy;
`ifdef BLAZE_TX_CMD_COUNT_EN
  logic [15:0] o_cmd_count;
`endif

  always #5 tb_clock_i = ~tb_clock_i;

  blaze_frame_transmitter dut (
    .i_clock           (tb_clock_i),
    .i_reset           (i_reset),
    .i_cmd_valid       (i_cmd_valid),
    .o_cmd_ready       (o_cmd_ready),
    .i_cmd_code        (i_cmd_code),
    .i_cmd_sel         (i_cmd_sel),
    .i_cmd_addr        (i_cmd_addr),
    .o_frame_to_mips   (o_frame_to_mips),
    .i_frame_from_mips (i_frame_from_mips),
    .o_rsp_valid       (o_rsp_valid),
    .o_rsp_data        (o_rsp_data),
`ifdef BLAZE_TX_CMD_COUNT_EN
    .o_cmd_count       (o_cmd_count),
`endif
    .o_busy            (o_busy)
  );

  // ---------------------------------------------------------------------------
  // Stimulus records
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [5:0]  code;
    logic [8:0]  sel;
    logic [15:0] addr;
    logic [31:0] from_mips;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] exp_frame;
    logic        exp_ready;
  } vec_t;

  int n_tests  = 0;
  int n_failed = 0;

  // ---------------------------------------------------------------------------
  // Reference model: remembers when the last command was accepted and what it
  // was. Every expected output is a function of the edges elapsed since then.
  // ---------------------------------------------------------------------------
  int          m_edge      = 0;
  int          m_acc_edge  = 0;
  int          m_total     = 0;
  bit          m_active    = 1'b0;
  bit          m_loaded    = 1'b0;
  logic [5:0]  m_code      = '0;
  logic [8:0]  m_sel       = '0;
  logic [15:0] m_addr      = '0;
  logic [31:0] m_rsp_data  = '0;
  bit          m_rsp_pulse = 1'b0;
  logic [15:0] m_count     = '0;

  task automatic model_edge(input in_t in);
    m_edge++;
    m_rsp_pulse = 1'b0;
    if (in.rst) begin
      m_active   = 1'b0;
      m_loaded   = 1'b0;
      m_rsp_data = '0;
      m_count    = '0;
    end else if (!m_active) begin
      if (in.valid) begin
        m_active   = 1'b1;
        m_loaded   = 1'b1;
        m_acc_edge = m_edge;
        m_code     = in.code;
        m_sel      = in.sel;
        m_addr     = in.addr;
        m_total    = H + G + ((in.code == C_REQ_DATA) ? W : 0);
        m_count    = m_count + 16'd1;
      end
    end else if (m_edge - m_acc_edge == m_total) begin
      m_active = 1'b0;
      if (m_code == C_REQ_DATA) begin
        m_rsp_data  = in.from_mips;
        m_rsp_pulse = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] model_frame();
    logic v;
    if (!m_loaded) return 32'h0;
    v = m_active && ((m_edge - m_acc_edge) < H);
    return {m_code, v, m_sel, m_addr};
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
  task automatic step(input in_t in);
    i_reset           = in.rst;
    i_cmd_valid       = in.valid;
    i_cmd_code        = in.code;
    i_cmd_sel         = in.sel;
    i_cmd_addr        = in.addr;
    i_frame_from_mips = in.from_mips;
    model_edge(in);
    @(posedge tb_clock_i);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".frame"},     o_frame_to_mips, model_frame());
    check({tag, ".ready"},     32'(o_cmd_ready), 32'(!m_active));
    check({tag, ".busy"},      32'(o_busy),      32'(m_active));
    check({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'(m_rsp_pulse));
    check({tag, ".rsp_data"},  o_rsp_data,      m_rsp_data);
`ifdef BLAZE_TX_CMD_COUNT_EN
    check({tag, ".cmd_count"}, 32'(o_cmd_count), 32'(m_count));
`endif
  endtask

  function automatic in_t mk_in(input logic rst, input logic valid, input logic [5:0] code,
                                input logic [8:0] sel, input logic [15:0] addr,
                                input logic [31:0] from_mips);
    in_t r;
    r.rst = rst; r.valid = valid; r.code = code;
    r.sel = sel; r.addr = addr; r.from_mips = from_mips;
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, input logic valid, input logic [5:0] code,
                              input logic [8:0] sel, input logic [15:0] addr,
                              input logic [31:0] exp_frame, input logic exp_ready);
    vec_t v;
    v.in        = mk_in(rst, valid, code, sel, addr, 32'h1234_5678);
    v.exp_frame = exp_frame;
    v.exp_ready = exp_ready;
    return v;
  endfunction

  function automatic logic [5:0] rand_code();
    case ($urandom_range(0, 6))
      0:       return C_START;
      1:       return C_RESET;
      2, 3:    return C_REQ_DATA;
      4:       return C_SET_MODE;
      5:       return C_STEP;
      default: return 6'($urandom);
    endcase
  endfunction

  // Watchdog: the run is fixed-length, so this only fires if the simulation
  // stops advancing as expected.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t tbl[16];

  initial begin
    in_t in;
    int  seen;

    // Directed table: reset, RESET command, then SET_MODE and START
    // back-to-back with valid held high. START is offered while busy and must
    // be ignored until ready returns.
    tbl[0]  = mk(1, 0, 6'h0,       9'h000, 16'h0000, 32'h0000_0000, 1);
    tbl[1]  = mk(0, 1, C_RESET,    9'h000, 16'h0000, 32'h0A00_0000, 0);
    tbl[2]  = mk(0, 0, C_RESET,    9'h000, 16'h0000, 32'h0A00_0000, 0);
    tbl[3]  = mk(0, 0, C_RESET,    9'h000, 16'h0000, 32'h0800_0000, 0);
    tbl[4]  = mk(0, 0, C_RESET,    9'h000, 16'h0000, 32'h0800_0000, 0);
    tbl[5]  = mk(0, 0, C_RESET,    9'h000, 16'h0000, 32'h0800_0000, 1);
    tbl[6]  = mk(0, 1, C_SET_MODE, 9'h1A5, 16'h1234, 32'h2BA5_1234, 0);
    tbl[7]  = mk(0, 1, C_START,    9'h000, 16'h00FF, 32'h2BA5_1234, 0);
    tbl[8]  = mk(0, 1, C_START,    9'h000, 16'h00FF, 32'h29A5_1234, 0);
    tbl[9]  = mk(0, 1, C_START,    9'h000, 16'h00FF, 32'h29A5_1234, 0);
    tbl[10] = mk(0, 1, C_START,    9'h000, 16'h00FF, 32'h29A5_1234, 1);
    tbl[11] = mk(0, 1, C_START,    9'h000, 16'h00FF, 32'h0600_00FF, 0);
    tbl[12] = mk(0, 0, C_START,    9'h000, 16'h00FF, 32'h0600_00FF, 0);
    tbl[13] = mk(0, 0, C_START,    9'h000, 16'h00FF, 32'h0400_00FF, 0);
    tbl[14] = mk(0, 0, C_START,    9'h000, 16'h00FF, 32'h0400_00FF, 0);
    tbl[15] = mk(0, 0, C_START,    9'h000, 16'h00FF, 32'h0400_00FF, 1);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].in);
      check($sformatf("tbl%0d.frame", i), o_frame_to_mips, tbl[i].exp_frame);
      check($sformatf("tbl%0d.ready", i), 32'(o_cmd_ready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d.busy", i),  32'(o_busy),      32'(!tbl[i].exp_ready));
      check($sformatf("tbl%0d.rsp_valid", i), 32'(o_rsp_valid), 32'h0);
      check($sformatf("tbl%0d.rsp_data", i),  o_rsp_data,      32'h0);
    end

    // REQ_DATA: the reply pulse arrives 8 edges after the accept edge (the
    // ninth cycle after the accept cycle), and the data is held afterwards.
    in = mk_in(0, 1, C_REQ_DATA, 9'h002, 16'h0040, 32'hDEAD_BEEF);
    step(in);
    check_model("req_acc");
    check("req_acc.frame_const", o_frame_to_mips, 32'h0E02_0040);
    in.valid = 1'b0;
    seen = -1;
    for (int d = 1; d <= 12; d++) begin
      step(in);
      check_model($sformatf("req_d%0d", d));
      if (o_rsp_valid && seen < 0) seen = d;
    end
    check("req.latency", 32'(seen), 32'd8);
    check("req.rsp_data", o_rsp_data, 32'hDEAD_BEEF);

    // A non-reply command must leave the captured data untouched.
    in = mk_in(0, 1, C_STEP, 9'h0F0, 16'hBEEF, 32'h0000_0000);
    step(in);
    in.valid = 1'b0;
    for (int d = 1; d <= 8; d++) begin
      step(in);
      check_model($sformatf("step_d%0d", d));
    end
    check("hold.rsp_data", o_rsp_data, 32'hDEAD_BEEF);

    // The next REQ_DATA replaces the captured data.
    in = mk_in(0, 1, C_REQ_DATA, 9'h1FF, 16'hFFFF, 32'hCAFE_F00D);
    step(in);
    in.valid = 1'b0;
    for (int d = 1; d <= 10; d++) begin
      step(in);
      check_model($sformatf("req2_d%0d", d));
    end
    check("req2.rsp_data", o_rsp_data, 32'hCAFE_F00D);

    // Reset during HOLD aborts the command: no further frame and no reply.
    in = mk_in(0, 1, C_REQ_DATA, 9'h003, 16'h0101, 32'h5555_AAAA);
    step(in);
    in.valid = 1'b0;
    step(in);
    check("abort.pre_frame", o_frame_to_mips, 32'h0E03_0101);
    in.rst = 1'b1;
    step(in);
    check("abort.frame", o_frame_to_mips, 32'h0);
    check("abort.ready", 32'(o_cmd_ready), 32'h1);
    check("abort.rsp_valid", 32'(o_rsp_valid), 32'h0);
    in.rst = 1'b0;
    for (int d = 1; d <= 12; d++) begin
      step(in);
      check($sformatf("abort_d%0d.rsp_valid", d), 32'(o_rsp_valid), 32'h0);
      check($sformatf("abort_d%0d.frame", d), o_frame_to_mips, 32'h0);
      check_model($sformatf("abort_d%0d", d));
    end

    // A request in the same cycle as reset is dropped.
    in = mk_in(1, 1, C_START, 9'h001, 16'h0001, 32'h0);
    step(in);
    in.rst = 1'b0;
    in.valid = 1'b0;
    step(in);
    check("rst_drop.frame", o_frame_to_mips, 32'h0);
    check("rst_drop.ready", 32'(o_cmd_ready), 32'h1);

    // Randomized traffic checked against the model.
    for (int c = 0; c < 600; c++) begin
      in.rst       = ($urandom_range(0, 59) == 0);
      in.valid     = ($urandom_range(0, 9) < 6);
      in.code      = rand_code();
      in.sel       = 9'($urandom);
      in.addr      = 16'($urandom);
      in.from_mips = $urandom;
      step(in);
      check_model($sformatf("rnd%0d", c));
    end

`ifdef BLAZE_TX_CMD_COUNT_EN
    // Counter: three accepts from reset, then a wrap from 16'hFFFF.
    in = mk_in(1, 0, C_START, 9'h0, 16'h0, 32'h0);
    step(in);
    in.rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in.valid = 1'b1;
      step(in);
      in.valid = 1'b0;
      for (int d = 1; d <= 4; d++) step(in);
    end
    check("count.three", 32'(o_cmd_count), 32'd3);
    force dut.cmd_count_q = 16'hFFFF;
    #1;
    release dut.cmd_count_q;
    m_count = 16'hFFFF;
    in.valid = 1'b1;
    step(in);
    check("count.wrap", 32'(o_cmd_count), 32'd0);
    in.valid = 1'b0;
    for (int d = 1; d <= 4; d++) step(in);
    check_model("count.after");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
